// File: rtl/fir_pkg.sv
// Shared types, default DSP widths and the output saturation helper for fir_interp_poly.
package fir_pkg;

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_MAC,
        ST_DRAIN,
        ST_OUT
    } state_t;

    localparam int FIR_INTERP    = 8;
    localparam int FIR_TAPS      = 7;
    localparam int FIR_DATA_W    = 18;
    localparam int FIR_COEF_W    = 18;
    localparam int FIR_ACC_W     = 48;
    localparam int FIR_OUT_SHIFT = 16;
    localparam int SAT_W         = 64;

    // Clamp a shifted accumulator to the dw-bit signed range; caller keeps the low dw bits.
    function automatic logic [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v, input int dw);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Latency: read data valid one cycle after rd_vld.
// Backpressure: none; both ports accept every cycle.
module dp_ram #(
    parameter int W  = 36,
    parameter int D  = 7,
    parameter int AW = $clog2(D)
) (
    input  logic          clk,
    input  logic          wr_vld,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_vld,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_dat
);

    logic [W-1:0] mem [D];

    always_ff @(posedge clk) begin
        if (wr_vld)
            mem[wr_addr] <= wr_dat;
        if (rd_vld)
            rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/fir_coef_bank.sv
// Coefficient register file, INTERP*TAPS entries indexed k*INTERP+p, cleared by reset.
// Latency: write lands on the next edge; read is combinational on {k,p}.
// Backpressure: none; the caller gates wr_vld.
module fir_coef_bank #(
    parameter int INTERP = 8,
    parameter int TAPS   = 7,
    parameter int COEF_W = 18,
    parameter int AW     = $clog2(INTERP*TAPS),
    parameter int KW     = $clog2(TAPS),
    parameter int PW     = $clog2(INTERP)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_vld,
    input  logic [AW-1:0]     wr_addr,
    input  logic [COEF_W-1:0] wr_dat,
    input  logic [KW-1:0]     rd_k,
    input  logic [PW-1:0]     rd_p,
    output logic [COEF_W-1:0] rd_dat
);

    localparam int N = INTERP * TAPS;

    logic [COEF_W-1:0] regs [N];
    logic [AW-1:0]     rd_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++)
                regs[i] <= '0;
        end else if (wr_vld && (int'(wr_addr) < N)) begin
            regs[wr_addr] <= wr_dat;
        end
    end

    assign rd_idx = AW'(int'(rd_k) * INTERP + int'(rd_p));
    assign rd_dat = regs[rd_idx];

endmodule

// File: rtl/fir_interp_poly.sv
// Polyphase interpolating FIR: one stereo sample in, INTERP outputs per channel; FIR_INTERP_SAT_EN clamps outputs.
// Latency: phase p output appears (p+1)*(TAPS+3) cycles after the accept edge.
// Backpressure: none; strobes while busy are dropped and set the sticky overrun flag.
module fir_interp_poly
    import fir_pkg::*;
#(
    parameter int INTERP    = FIR_INTERP,
    parameter int TAPS      = FIR_TAPS,
    parameter int DATA_W    = FIR_DATA_W,
    parameter int COEF_W    = FIR_COEF_W,
    parameter int ACC_W     = FIR_ACC_W,
    parameter int OUT_SHIFT = FIR_OUT_SHIFT,
    localparam int CAW      = $clog2(INTERP*TAPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_in_rdy,
    input  logic [DATA_W-1:0] sample_in_l,
    input  logic [DATA_W-1:0] sample_in_r,
    output logic              sample_out_rdy,
    output logic [DATA_W-1:0] sample_out_l,
    output logic [DATA_W-1:0] sample_out_r,
    output logic              done,
    output logic              busy,
    output logic              overrun,
    input  logic              coef_wr,
    input  logic [CAW-1:0]    coef_addr,
    input  logic [COEF_W-1:0] coef_data
);

    localparam int KW     = $clog2(TAPS);
    localparam int PW     = $clog2(INTERP);
    localparam int PROD_W = DATA_W + COEF_W;

    state_t state, state_nxt;

    logic [KW-1:0]          k_cnt, head, base, ram_wa, ram_ra;
    logic [KW:0]            rd_sum;
    logic [PW-1:0]          p_cnt;
    logic                   drain, accept, ram_we, ram_re, vld1, vld2, p_last;
    logic [2*DATA_W-1:0]    ram_wd, ram_rd;
    logic [COEF_W-1:0]      coef_rd;
    logic signed [COEF_W-1:0] coef_q;
    logic signed [DATA_W-1:0] x_l, x_r;
    logic signed [PROD_W-1:0] prod_l, prod_r;
    logic signed [ACC_W-1:0]  acc_l, acc_r;
    logic [DATA_W-1:0]      res_l, res_r;

    // Newest sample sits at base; older ones follow at increasing indices.
    assign rd_sum = {1'b0, base} + {1'b0, k_cnt};
    assign ram_ra = (rd_sum >= (KW+1)'(TAPS)) ? KW'(rd_sum - (KW+1)'(TAPS)) : rd_sum[KW-1:0];
    assign x_l    = ram_rd[2*DATA_W-1:DATA_W];
    assign x_r    = ram_rd[DATA_W-1:0];
    assign p_last = (p_cnt == PW'(INTERP-1));

`ifdef FIR_INTERP_SAT_EN
    assign res_l = DATA_W'(saturate(SAT_W'(acc_l >>> OUT_SHIFT), DATA_W));
    assign res_r = DATA_W'(saturate(SAT_W'(acc_r >>> OUT_SHIFT), DATA_W));
`else
    assign res_l = DATA_W'(acc_l >>> OUT_SHIFT);
    assign res_r = DATA_W'(acc_r >>> OUT_SHIFT);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_FLUSH;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        accept    = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_wa    = head;
        ram_wd    = {sample_in_l, sample_in_r};
        case (state)
            ST_FLUSH: begin
                ram_we = 1'b1;
                ram_wa = k_cnt;
                ram_wd = '0;
                if (k_cnt == KW'(TAPS-1))
                    state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                busy = 1'b0;
                if (sample_in_rdy) begin
                    accept    = 1'b1;
                    ram_we    = 1'b1;
                    state_nxt = ST_MAC;
                end
            end
            ST_MAC: begin
                ram_re = 1'b1;
                if (k_cnt == KW'(TAPS-1))
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (drain) state_nxt = ST_OUT;
            ST_OUT:   state_nxt = p_last ? ST_IDLE : ST_MAC;
            default:  state_nxt = ST_FLUSH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_cnt          <= '0;
            drain          <= 1'b0;
            head           <= '0;
            base           <= '0;
            p_cnt          <= '0;
            overrun        <= 1'b0;
            vld1           <= 1'b0;
            vld2           <= 1'b0;
            coef_q         <= '0;
            prod_l         <= '0;
            prod_r         <= '0;
            acc_l          <= '0;
            acc_r          <= '0;
            sample_out_rdy <= 1'b0;
            sample_out_l   <= '0;
            sample_out_r   <= '0;
            done           <= 1'b0;
        end else begin
            k_cnt <= ((state == ST_FLUSH || state == ST_MAC) && state_nxt == state) ? k_cnt + 1'b1 : '0;
            drain <= (state == ST_DRAIN) && !drain;
            if (accept) begin
                head  <= (head == '0) ? KW'(TAPS-1) : head - 1'b1;
                base  <= head;
                p_cnt <= '0;
            end else if (state == ST_OUT) begin
                p_cnt <= p_cnt + 1'b1;
            end
            if (sample_in_rdy && busy)
                overrun <= 1'b1;

            // Read -> multiply -> accumulate; the two DRAIN cycles cover the tail.
            vld1   <= ram_re;
            coef_q <= coef_rd;
            prod_l <= x_l * coef_q;
            prod_r <= x_r * coef_q;
            vld2   <= vld1;
            if (state_nxt == ST_MAC && state != ST_MAC) begin
                acc_l <= '0;
                acc_r <= '0;
            end else if (vld2) begin
                acc_l <= acc_l + ACC_W'(prod_l);
                acc_r <= acc_r + ACC_W'(prod_r);
            end

            sample_out_rdy <= (state == ST_OUT);
            done           <= (state == ST_OUT) && p_last;
            sample_out_l   <= (state == ST_OUT) ? res_l : '0;
            sample_out_r   <= (state == ST_OUT) ? res_r : '0;
        end
    end

    dp_ram #(
        .W (2*DATA_W),
        .D (TAPS)
    ) u_hist (
        .clk     (clk),
        .wr_vld  (ram_we),
        .wr_addr (ram_wa),
        .wr_dat  (ram_wd),
        .rd_vld  (ram_re),
        .rd_addr (ram_ra),
        .rd_dat  (ram_rd)
    );

    fir_coef_bank #(
        .INTERP (INTERP),
        .TAPS   (TAPS),
        .COEF_W (COEF_W)
    ) u_coef (
        .clk     (clk),
        .reset   (reset),
        .wr_vld  (coef_wr && !busy),
        .wr_addr (coef_addr),
        .wr_dat  (coef_data),
        .rd_k    (k_cnt),
        .rd_p    (p_cnt),
        .rd_dat  (coef_rd)
    );

endmodule

// File: doc/fir_interp_poly.md
# fir_interp_poly

Parametrised polyphase interpolating FIR for the sigma-delta DAC path. Takes one stereo sample per input strobe and emits INTERP output samples per channel, one per phase. Left and right share one sequencer, with one internal MAC per channel. Adds three things to the fixed 8x stage: runtime-loadable coefficients, history flush on reset, and overrun/saturation handling.

## Interface
- INTERP, 8: interpolation factor L (number of phases), ≥2
- TAPS, 7: taps per phase T, ≥2
- DATA_W, 18: sample width, signed
- COEF_W, 18: coefficient width, signed
- ACC_W, 48: accumulator width
- OUT_SHIFT, 16: output = acc[OUT_SHIFT+DATA_W-1:OUT_SHIFT]
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- sample_in_rdy  in  1  input strobe, one-cycle pulse
- sample_in_l / sample_in_r  in  DATA_W  signed input samples
- sample_out_rdy  out  1  one-cycle pulse per phase output
- sample_out_l / sample_out_r  out  DATA_W  signed outputs, zero when sample_out_rdy is low
- done  out  1  pulses together with the last-phase sample_out_rdy
- busy  out  1  high in FLUSH and in MAC/DRAIN/OUT
- overrun  out  1  sticky; cleared only by reset
- coef_wr  in  1  coefficient write strobe
- coef_addr  in  clog2(INTERP*TAPS)  coefficient index k*INTERP+p
- coef_data  in  COEF_W  signed coefficient

## Operation
- Reset: every output is 0, all coefficients are 0, and the state is FLUSH.
- FLUSH: writes zero to all TAPS history entries (TAPS cycles, busy=1), then goes to IDLE.
- IDLE: on sample_in_rdy, writes {l,r} at the history head, moves the head back one entry (wraps 0 to TAPS-1) and enters MAC with p=0.
- MAC (T cycles): reads x[n-k] for k=0..T-1 from the circular index head+k mod TAPS. Each channel computes acc += c[k*INTERP+p] * x[n-k].
- DRAIN (2 cycles): empties the read/multiply pipeline.
- OUT (1 cycle): registers the outputs and pulses sample_out_rdy. If p=INTERP-1, also pulses done and returns to IDLE. Otherwise p increments, acc clears, and the state returns to MAC.
- Arithmetic:
  - Product is DATA_W+COEF_W signed and sign-extended to ACC_W.
  - acc clears at MAC entry.
  - Output slice is defined by OUT_SHIFT, as listed under Interface.
- sample_in_rdy while busy: the sample is dropped, history is untouched, and overrun is set.
- coef_wr while idle: writes the register on the next edge.
- coef_wr while busy: the write is dropped.
- coef_wr and sample_in_rdy in the same IDLE cycle: both take effect, and the new coefficient is used by the filtering that sample starts.
- Reset mid-operation: aborts immediately, clears outputs and coefficients, and restarts FLUSH.

## Timing
- Accept edge: edge E0, where sample_in_rdy is sampled high in IDLE.
- Each phase takes T+3 cycles. The phase p output is valid in the cycle after edge E0+(p+1)*(T+3).
- busy stays high for INTERP*(T+3) cycles after E0 and drops in the cycle after the last output.
- Defaults (L=8, T=7): 80 cycles per input. Minimum input spacing is INTERP*(T+3)+1 cycles.
- After reset deasserts, the first sample is accepted no earlier than TAPS cycles later, once FLUSH completes.

## Configuration
- FIR_INTERP_SAT_EN defined: if acc is outside the DATA_W-signed range after the shift, the output clamps to max positive (0x1FFFF at DATA_W=18) or min negative (0x20000).
- FIR_INTERP_SAT_EN undefined: plain slice truncation with wrap-around. No extra logic.

## Structure
- Shared package fir_pkg holds:
  - the state encoding (FLUSH, IDLE, MAC, DRAIN, OUT)
  - the DSP width constants
  - the saturate helper function
- Sub-module fir_coef_bank: register file of INTERP*TAPS x COEF_W entries. It has an async-reset-to-zero write port and a combinational read port addressed by {k,p}.
- The history buffer is a dp_ram instance, DATA_W*2 wide and TAPS deep.

## Test plan
- Phase gain:
  - Load c[p]=0x100*(p+1) for k=0 and zero elsewhere.
  - Input l=r=0x1000.
  - Outputs 0x10, 0x20, …, 0x80 in phase order; done with the 8th output.
- Impulse response:
  - Load c[n]=n for n=0..55.
  - Input 0x10000, then zeros at spacing 81.
  - Output stream reads 0..55, then zeros, on both channels.
- Overrun:
  - Send a second strobe 40 cycles after the first.
  - The second strobe is ignored, the first block's 8 outputs are unchanged, and overrun=1 until reset.
- Saturation:
  - All coefficients 0x1FFFF, constant input 0x1FFFF.
  - With FIR_INTERP_SAT_EN: output 0x1FFFF.
  - Without it: the truncated slice of acc.
- Coefficient write while busy:
  - Write c[0]=0x7FFF during MAC.
  - The next block still uses the old c[0].
- Reset mid-block:
  - Assert reset at output 3.
  - All outputs go to 0, busy stays high for TAPS cycles, and the next impulse yields a clean response with no stale history.
